// File: rtl/dsp_pkg.sv
// Shared definitions for the transform output stage.
//   SAMPLE_W : sample width (bit SAMPLE_W-1 = sign, lower bits = magnitude)
//   NPT      : points per frame
//   sample_t : one sample
//   bitrev3  : 3-bit index bit reversal (bin <-> lane mapping)
//   sm_to_tc : sign-magnitude to two's complement conversion
package dsp_pkg;

  localparam int SAMPLE_W = 12;
  localparam int NPT      = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Negative zero negates to zero, and +/-2047 always fits, so no saturation.
  function automatic sample_t sm_to_tc(input sample_t sm);
    sample_t mag;
    mag = {1'b0, sm[SAMPLE_W-2:0]};
    return sm[SAMPLE_W-1] ? sample_t'(-mag) : mag;
  endfunction

endpackage

// File: rtl/dsp_frame_bank.sv
// One frame buffer: NPT x W registers, all lanes written together.
// Ports:
//   CLK  : clock
//   we   : write enable, loads every lane from d
//   d    : parallel frame, lane k in d[k]
//   ridx : read lane index
//   q    : lane ridx, combinational from the registers
module dsp_frame_bank
  import dsp_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic                   CLK,
  input  logic                   we,
  input  logic [NPT-1:0][W-1:0]  d,
  input  logic [2:0]             ridx,
  output logic [W-1:0]           q
);

  logic [NPT-1:0][W-1:0] mem;

  // NOTE: data storage has no reset; the full flags alone say whether a bank
  // holds anything, so resetting the contents would only cost flops.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem <= d;
    end
  end

  assign q = mem[ridx];

endmodule

// File: rtl/dsp_out_serializer.sv
// Ping-pong output serializer for the 8-point transform stage. Each accepted
// frame of eight parallel samples is streamed out one bin per cycle in natural
// bin order over a valid/ready handshake.
// Parameters:
//   W      : sample width (sign-magnitude)
//   BITREV : 1 = lane k holds bin bitrev3(k); 0 = lane n holds bin n
// Ports:
//   CLK, RESET            : clock, asynchronous active-high reset
//   IN_VALID / IN_READY   : frame handshake, I0..I7 parallel frame
//   OUT_VALID / OUT_READY : sample handshake
//   OUT_DATA, OUT_IDX     : current sample and its bin index
//   OUT_LAST              : high with bin 7
// Build option: define DSP_OUT_SER_TWOS_COMP_EN to emit OUT_DATA in two's
// complement instead of raw sign-magnitude.
module dsp_out_serializer
  import dsp_pkg::*;
#(
  parameter int W      = SAMPLE_W,
  parameter bit BITREV = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  input  logic [W-1:0] I4,
  input  logic [W-1:0] I5,
  input  logic [W-1:0] I6,
  input  logic [W-1:0] I7,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT_DATA,
  output logic [2:0]   OUT_IDX,
  output logic         OUT_LAST
);

  logic [1:0] full, full_nxt;
  logic       wr_sel, rd_sel;
  logic [2:0] rd_cnt;

  logic [NPT-1:0][W-1:0] frame;
  logic                  in_acc, out_xfer, frame_done;
  logic [2:0]            rd_lane;
  logic [W-1:0]          q0, q1, raw;

  assign frame[0] = I0;
  assign frame[1] = I1;
  assign frame[2] = I2;
  assign frame[3] = I3;
  assign frame[4] = I4;
  assign frame[5] = I5;
  assign frame[6] = I6;
  assign frame[7] = I7;

  // Both handshakes depend only on registers, so there is no ready-to-ready
  // combinational path through this block.
  assign IN_READY   = ~full[wr_sel];
  assign OUT_VALID  = full[rd_sel];
  assign in_acc     = IN_VALID & IN_READY;
  assign out_xfer   = OUT_VALID & OUT_READY;
  assign frame_done = out_xfer & (rd_cnt == 3'd7);

  // Accept and release always hit different banks (a full bank is never
  // written), so setting one flag and clearing the other cannot collide.
  // NOTE: every signal written in always_comb gets a default first, which
  // keeps the block free of inferred latches.
  always_comb begin
    full_nxt = full;
    if (in_acc)     full_nxt[wr_sel] = 1'b1;
    if (frame_done) full_nxt[rd_sel] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      rd_cnt <= 3'd0;
    end else begin
      full <= full_nxt;
      if (in_acc) wr_sel <= ~wr_sel;
      if (frame_done) begin
        rd_cnt <= 3'd0;
        rd_sel <= ~rd_sel;
      end else if (out_xfer) begin
        rd_cnt <= rd_cnt + 3'd1;
      end
    end
  end

  assign rd_lane = BITREV ? bitrev3(rd_cnt) : rd_cnt;

  dsp_frame_bank #(.W(W)) u_bank0 (
    .CLK  (CLK),
    .we   (in_acc & ~wr_sel),
    .d    (frame),
    .ridx (rd_lane),
    .q    (q0)
  );

  dsp_frame_bank #(.W(W)) u_bank1 (
    .CLK  (CLK),
    .we   (in_acc & wr_sel),
    .d    (frame),
    .ridx (rd_lane),
    .q    (q1)
  );

  assign raw = rd_sel ? q1 : q0;

  // Bank contents are undefined after reset, so data is forced to zero
  // whenever no sample is being presented.
`ifdef DSP_OUT_SER_TWOS_COMP_EN
  assign OUT_DATA = OUT_VALID ? W'(sm_to_tc(sample_t'(raw))) : '0;
`else
  assign OUT_DATA = OUT_VALID ? raw : '0;
`endif

  assign OUT_IDX  = rd_cnt;
  assign OUT_LAST = OUT_VALID & (rd_cnt == 3'd7);

endmodule

// File: tb/tb_dsp_out_serializer.sv
// Directed bench for dsp_out_serializer. Two instances share all inputs:
// dut0 with BITREV=0 and dut1 with BITREV=1.
module tb_dsp_out_serializer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [11:0] lane [8];

  logic        in_ready0, out_valid0, out_last0;
  logic [11:0] out_data0;
  logic [2:0]  out_idx0;
  logic        in_ready1, out_valid1, out_last1;
  logic [11:0] out_data1;
  logic [2:0]  out_idx1;

  int checks = 0;
  int errors = 0;

  // bin n of the BITREV=1 instance comes from lane brv[n]
  int brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 CLK = ~CLK;

  dsp_out_serializer #(.W(12), .BITREV(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready0),
    .I0(lane[0]), .I1(lane[1]), .I2(lane[2]), .I3(lane[3]),
    .I4(lane[4]), .I5(lane[5]), .I6(lane[6]), .I7(lane[7]),
    .OUT_VALID(out_valid0), .OUT_READY(OUT_READY), .OUT_DATA(out_data0),
    .OUT_IDX(out_idx0), .OUT_LAST(out_last0)
  );

  dsp_out_serializer #(.W(12), .BITREV(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
    .I0(lane[0]), .I1(lane[1]), .I2(lane[2]), .I3(lane[3]),
    .I4(lane[4]), .I5(lane[5]), .I6(lane[6]), .I7(lane[7]),
    .OUT_VALID(out_valid1), .OUT_READY(OUT_READY), .OUT_DATA(out_data1),
    .OUT_IDX(out_idx1), .OUT_LAST(out_last1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_frame(input logic [11:0] base);
    for (int k = 0; k < 8; k++) lane[k] = base + 12'(k);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready0"},  32'(in_ready0),  32'd1);
    check({tag, " in_ready1"},  32'(in_ready1),  32'd1);
    check({tag, " out_valid0"}, 32'(out_valid0), 32'd0);
    check({tag, " out_valid1"}, 32'(out_valid1), 32'd0);
    check({tag, " out_last0"},  32'(out_last0),  32'd0);
    check({tag, " out_idx0"},   32'(out_idx0),   32'd0);
    check({tag, " out_data0"},  32'(out_data0),  32'd0);
    check({tag, " out_data1"},  32'(out_data1),  32'd0);
  endtask

  // One presented sample of a frame whose lane k holds base+k.
  task automatic check_sample(input string tag, input logic [11:0] base, input int n);
    check({tag, " valid0"}, 32'(out_valid0), 32'd1);
    check({tag, " valid1"}, 32'(out_valid1), 32'd1);
    check({tag, " idx0"},   32'(out_idx0),   32'(n));
    check({tag, " idx1"},   32'(out_idx1),   32'(n));
    check({tag, " data0"},  32'(out_data0),  32'(base + 12'(n)));
    check({tag, " data1"},  32'(out_data1),  32'(base + 12'(brv[n])));
    check({tag, " last0"},  32'(out_last0),  32'(n == 7));
    check({tag, " last1"},  32'(out_last1),  32'(n == 7));
  endtask

  task automatic send_frame(input logic [11:0] base);
    set_frame(base);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask

`ifdef DSP_OUT_SER_TWOS_COMP_EN
  logic [11:0] tc_exp [8] = '{12'hFFB, 12'h000, 12'h7FF, 12'h801,
                              12'h000, 12'h001, 12'hF01, 12'h123};
`else
  logic [11:0] tc_exp [8] = '{12'h805, 12'h800, 12'h7FF, 12'hFFF,
                              12'h000, 12'h001, 12'h8FF, 12'h123};
`endif

  initial begin
    logic accepted;
    for (int k = 0; k < 8; k++) lane[k] = 12'h000;

    // Reset state
    #2;
    check_idle("reset");
    step();
    step();
    RESET = 1'b0;
    check_idle("post_reset");

    // Single frame, natural and bit-reversed order
    OUT_READY = 1'b1;
    send_frame(12'h001);
    for (int n = 0; n < 8; n++) begin
      check_sample("single", 12'h001, n);
      step();
    end
    check_idle("single_end");

    // Back-pressure: two frames fill both banks, a third is refused
    OUT_READY = 1'b0;
    send_frame(12'h010);
    check("bp in_ready after 1", 32'(in_ready0), 32'd1);
    send_frame(12'h020);
    set_frame(12'h030);
    IN_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("bp in_ready full0", 32'(in_ready0), 32'd0);
      check("bp in_ready full1", 32'(in_ready1), 32'd0);
      check_sample("bp hold", 12'h010, 0);
      step();
    end
    OUT_READY = 1'b1;
    accepted = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 8; n++) begin
        logic [11:0] base;
        base = 12'h010 * 12'(f + 1);
        check_sample("bp stream", base, n);
        if (!accepted) begin
          // frame 3 waits until frame 1's last sample frees bank 0
          check("bp in_ready", 32'(in_ready0), 32'(f == 1 && n == 0));
          accepted = (in_ready0 === 1'b1);
        end
        step();
        if (accepted) IN_VALID = 1'b0;
      end
    end
    check("bp frame3 accepted", 32'(accepted), 32'd1);
    check_idle("bp_end");

    // Stall mid-frame at bin 3
    send_frame(12'h040);
    for (int n = 0; n < 3; n++) begin
      check_sample("stall pre", 12'h040, n);
      step();
    end
    OUT_READY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_sample("stall hold", 12'h040, 3);
      step();
    end
    OUT_READY = 1'b1;
    for (int n = 3; n < 8; n++) begin
      check_sample("stall post", 12'h040, n);
      step();
    end
    check_idle("stall_end");

    // Asynchronous reset between edges at bin 5
    send_frame(12'h050);
    for (int n = 0; n < 5; n++) step();
    check_sample("arst pre", 12'h050, 5);
    #2;
    RESET = 1'b1;
    #1;
    check_idle("arst now");
    step();
    #2;
    RESET = 1'b0;
    step();
    check_idle("arst after");
    send_frame(12'h060);
    for (int n = 0; n < 8; n++) begin
      check_sample("arst next", 12'h060, n);
      step();
    end
    check_idle("arst_end");

    // Sign-magnitude edge values (raw or converted depending on build)
    lane[0] = 12'h805; lane[1] = 12'h800; lane[2] = 12'h7FF; lane[3] = 12'hFFF;
    lane[4] = 12'h000; lane[5] = 12'h001; lane[6] = 12'h8FF; lane[7] = 12'h123;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check("tc idx0",  32'(out_idx0),  32'(n));
      check("tc data0", 32'(out_data0), 32'(tc_exp[n]));
      check("tc data1", 32'(out_data1), 32'(tc_exp[brv[n]]));
      step();
    end
    check_idle("tc_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
